booth_mult_seq: RTL and testbench

- Iterative radix-4 Booth multiplier controller for signed 16x16 operands.
- Latches an operand pair and walks the multiplier one Booth group per cycle through a single shared `booth_recoder` instance (16-bit, 17-bit `pp` plus correction bit `s`).
- Accumulates the shifted partial products into a 32-bit product.
- Returns the product over a valid/ready handshake. It is the sequencing front-end for the Booth datapath in the `Booth_Multi` area.

---
 rtl/booth_mult_seq.sv | 145 ++++++++++++++
 tb/tb_booth_mult_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier: one Booth group per cycle through a shared
// recoder, accumulating into a 32-bit product returned over a valid/ready handshake.

module booth_recoder #(
  parameter int BITWIDTH = 16
) (
  input  logic [BITWIDTH-1:0] multiplicand,
  input  logic [2:0]          code,
  output logic [BITWIDTH:0]   pp,
  output logic                s
);
  logic [BITWIDTH:0] a_ext;
  logic [BITWIDTH:0] a_dbl;

  assign a_ext = {multiplicand[BITWIDTH-1], multiplicand};
  assign a_dbl = {multiplicand, 1'b0};

  // Negative codes emit the one's complement; s supplies the +1 so code 111 nets to zero.
  always_comb begin
    pp = '0;
    s  = 1'b0;
    unique case (code)
      3'b000:          begin pp = '0;     s = 1'b0; end
      3'b001, 3'b010:  begin pp = a_ext;  s = 1'b0; end
      3'b011:          begin pp = a_dbl;  s = 1'b0; end
      3'b100:          begin pp = ~a_dbl; s = 1'b1; end
      3'b101, 3'b110:  begin pp = ~a_ext; s = 1'b1; end
      3'b111:          begin pp = '1;     s = 1'b1; end
      default:         begin pp = '0;     s = 1'b0; end
    endcase
  end
endmodule

module booth_mult_seq #(
  parameter int BITWIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BITWIDTH-1:0]     multiplicand,
  input  logic [BITWIDTH-1:0]     multiplier,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*BITWIDTH-1:0]   product,
  output logic                    busy
);
  localparam int PW = 2 * BITWIDTH;
  localparam int NGROUPS = BITWIDTH / 2;
  localparam int CW = $clog2(NGROUPS);
  localparam logic [CW-1:0] LAST_GROUP = CW'(NGROUPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [BITWIDTH-1:0]   a_q, a_d;
  logic [BITWIDTH:0]     b_q, b_d;
  logic [PW-1:0]         acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         product_q, product_d;

  logic [BITWIDTH:0]     pp;
  logic                  pp_s;
  logic [PW-1:0]         pp_ext;
  logic [PW-1:0]         s_ext;
  logic [CW:0]           shamt;
  logic [PW-1:0]         acc_sum;

  booth_recoder #(.BITWIDTH(BITWIDTH)) u_recoder (
    .multiplicand (a_q),
    .code         (b_q[2:0]),
    .pp           (pp),
    .s            (pp_s)
  );

  // Each group is weighted by 4^cnt; the correction bit carries the same weight.
  assign pp_ext  = {{(PW-BITWIDTH-1){pp[BITWIDTH]}}, pp};
  assign s_ext   = {{(PW-1){1'b0}}, pp_s};
  assign shamt   = {cnt_q, 1'b0};
  assign acc_sum = acc_q + (pp_ext << shamt) + (s_ext << shamt);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = multiplicand;
          b_d     = {multiplier, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_sum;
        b_d   = {{2{b_q[BITWIDTH]}}, b_q[BITWIDTH:2]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_GROUP) begin
          product_d = acc_sum;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign product   = product_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed vector table, handshake corner
// sequences, and randomized back-to-back traffic against an integer-multiply model.

module tb_booth_mult_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  int checks = 0;
  int failures = 0;

  booth_mult_seq #(.BITWIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int ai;
    int bi;
    ai = int'($signed(a));
    bi = int'($signed(b));
    return ai * bi;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Offers one pair from IDLE and returns at the first negedge with out_valid high.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ordy,
                       output logic [31:0] prod, output int lat);
    multiplicand = a;
    multiplier   = b;
    in_valid     = 1'b1;
    out_ready    = ordy;
    @(negedge clk);
    in_valid     = 1'b0;
    multiplicand = 16'($urandom);
    multiplier   = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check32("timeout_out_valid", {31'b0, out_valid}, 32'd1);
    prod = product;
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_in_ready"},  {31'b0, in_ready},  32'd1);
    check32({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check32({tag, "_busy"},      {31'b0, busy},      32'd0);
    check32({tag, "_product"},   product,            32'd0);
  endtask

  vec_t vecs[9];
  logic [31:0] prod;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  int lat;
  int seen;

  initial begin
    vecs[0] = '{16'd3,    16'd5,    32'h0000000F};
    vecs[1] = '{16'h8000, 16'h8000, 32'h40000000};
    vecs[2] = '{16'h8000, 16'h7FFF, 32'hC0008000};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 32'h00000001};
    vecs[4] = '{16'h1234, 16'h0000, 32'h00000000};
    vecs[5] = '{16'h1234, 16'hFFFF, 32'hFFFFEDCC};
    vecs[6] = '{16'h0007, 16'hFFF7, 32'hFFFFFFC1};
    vecs[7] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    vecs[8] = '{16'd100,  16'd200,  32'h00004E20};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    multiplicand = '0; multiplier = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed table; every entry also checks latency and the single-cycle DONE.
    for (int i = 0; i < 9; i++) begin
      check32("table_idle_ready", {31'b0, in_ready}, 32'd1);
      do_op(vecs[i].a, vecs[i].b, 1'b1, prod, lat);
      check32("table_product", prod, vecs[i].exp);
      check32("table_latency", 32'(lat), 32'd8);
      check32("table_busy_done", {31'b0, busy}, 32'd1);
      $display("vec %0d a=%h b=%h product=%h latency=%0d", i, vecs[i].a, vecs[i].b, prod, lat);
      @(negedge clk);
      check32("table_valid_drop", {31'b0, out_valid}, 32'd0);
      check32("table_ready_back", {31'b0, in_ready}, 32'd1);
    end

    // Backpressure: product held, new offers ignored, then the next pair goes through.
    do_op(16'd7, 16'hFFF7, 1'b0, prod, lat);
    for (int c = 0; c < 20; c++) begin
      multiplicand = 16'd1;
      multiplier   = 16'd1;
      in_valid     = 1'b1;
      check32("bp_product",   product,            32'hFFFFFFC1);
      check32("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check32("bp_in_ready",  {31'b0, in_ready},  32'd0);
      @(negedge clk);
    end
    $display("backpressure a=0007 b=fff7 product=%h held 20 cycles", product);
    out_ready = 1'b1;
    @(negedge clk);
    check32("bp_release_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check32("bp_next_product", product, 32'd1);
    check32("bp_next_latency", 32'(lat), 32'd8);
    $display("after backpressure a=0001 b=0001 product=%h", product);
    @(negedge clk);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check32("bp_no_extra_result", 32'(seen), 32'd0);

    // Reset during RUN abandons the operation.
    multiplicand = 16'd100; multiplier = 16'd200; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    repeat (3) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midrst");
    for (int c = 0; c < 12; c++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check32("midrst_no_valid", 32'(seen), 32'd0);
    do_op(16'd100, 16'd200, 1'b1, prod, lat);
    check32("midrst_rerun", prod, 32'h00004E20);
    $display("after reset a=0064 b=00c8 product=%h", prod);
    @(negedge clk);

    // Randomized back-to-back traffic against the integer model, in order.
    begin
      int accepted = 0;
      int retired = 0;
      int cyc = 0;
      while ((accepted < 1000 || exp_q.size() > 0) && cyc < 40000) begin
        out_ready = 1'($urandom_range(0, 1));
        if (accepted < 1000) begin
          in_valid     = 1'b1;
          multiplicand = 16'($urandom);
          multiplier   = 16'($urandom);
        end else begin
          in_valid = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check32("rand_unexpected_result", product, 32'hXXXXXXXX);
          end else begin
            exp_v = exp_q.pop_front();
            check32("rand_product", product, exp_v);
            $display("rand %0d product=%h expected=%h", retired, product, exp_v);
            retired++;
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(ref_mul(multiplicand, multiplier));
          accepted++;
        end
        @(negedge clk);
        cyc++;
      end
      check32("rand_accepted", 32'(accepted), 32'd1000);
      check32("rand_retired", 32'(retired), 32'd1000);
      check32("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
